// File: rtl/hyperbus_phy2r_upsizer.sv
`default_nettype none
// ============================================================================
// Module  : hyperbus_phy2r_upsizer
// Brief   : HyperBus PHY return stream to AXI R beat packer/splitter with
//           output beat FIFO, error merging, truncated-burst fill and drain.
// Revision: 1.0 - initial release
// ============================================================================
module hyperbus_phy2r_upsizer #(
   parameter int AxiDataWidth = 64,
   parameter int NumPhys      = 1,
   parameter int OutDepth     = 2,
   parameter int AddrWidth    = $clog2(AxiDataWidth / 8),
   parameter int CntWidth     = AddrWidth + 9
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    trans_valid_i,
   output logic                    trans_ready_o,
   input  logic [AddrWidth-1:0]    trans_addr_i,
   input  logic [2:0]              trans_size_i,
   input  logic [7:0]              trans_len_i,
   input  logic                    phy_valid_i,
   output logic                    phy_ready_o,
   input  logic [16*NumPhys-1:0]   phy_data_i,
   input  logic                    phy_last_i,
   input  logic                    phy_error_i,
   output logic                    axi_valid_o,
   input  logic                    axi_ready_i,
   output logic [AxiDataWidth-1:0] axi_data_o,
   output logic                    axi_error_o,
   output logic                    axi_last_o
);

   localparam int c_PHY_W      = 16 * NumPhys;
   localparam int c_PHY_BYTES  = 2 * NumPhys;
   localparam int c_BEAT_BYTES = AxiDataWidth / 8;
   localparam int c_WORDS      = c_BEAT_BYTES / c_PHY_BYTES;
   localparam int c_PTR_W      = (OutDepth > 1) ? $clog2(OutDepth) : 1;
   localparam int c_FILL_W     = $clog2(OutDepth + 1);
   localparam int c_ENTRY_W    = AxiDataWidth + 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [CntWidth-1:0]     r_beat_addr;
   logic [CntWidth-1:0]     r_phy_cnt;
   logic [CntWidth-1:0]     w_size_bytes;
   logic [CntWidth-1:0]     w_beat_end;
   logic [7:0]              r_beat_idx;
   logic [7:0]              r_len;
   logic [2:0]              r_size;
   logic [AxiDataWidth-1:0] r_asm;
   logic                    r_err;
   logic                    r_word_err;
   logic                    r_last_seen;

   logic                    w_complete;
   logic                    w_is_last;
   logic                    w_full;
   logic                    w_trans_hs;
   logic                    w_word_acc;
   logic                    w_push;
   logic                    w_pop;
   logic [c_ENTRY_W-1:0]    w_push_entry;

   logic [c_ENTRY_W-1:0]    r_mem [OutDepth];
   logic [c_PTR_W-1:0]      r_wr_ptr;
   logic [c_PTR_W-1:0]      r_rd_ptr;
   logic [c_FILL_W-1:0]     r_fill;

   function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_W'(OutDepth - 1)) ? '0 : p + c_PTR_W'(1);
   endfunction

   assign w_size_bytes = CntWidth'(1) << r_size;
   assign w_beat_end   = (r_beat_addr & ~(w_size_bytes - CntWidth'(1))) + w_size_bytes;
   assign w_complete   = (r_phy_cnt >= w_beat_end);
   assign w_is_last    = (r_beat_idx == r_len);
   assign w_full       = (r_fill == c_FILL_W'(OutDepth));
   assign w_trans_hs   = trans_valid_i & trans_ready_o;
   assign w_word_acc   = phy_valid_i & phy_ready_o & (r_state == ST_STREAM);
   assign w_pop        = axi_valid_o & axi_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      trans_ready_o = 1'b0;
      phy_ready_o   = 1'b0;
      w_push        = 1'b0;
      w_push_entry  = {r_asm, r_err, w_is_last};
      case (r_state)
         ST_IDLE: begin
            trans_ready_o = 1'b1;
            if (trans_valid_i) begin
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            // Once the PHY has signalled its last word nothing more is taken.
            phy_ready_o = !w_complete && !w_full && !r_last_seen;
            if (w_complete && !w_full) begin
               w_push = 1'b1;
               if (w_is_last) begin
                  w_state_nxt = r_last_seen ? ST_IDLE : ST_DRAIN;
               end
            end else if (!w_complete && r_last_seen) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_push_entry = {{AxiDataWidth{1'b0}}, 1'b1, w_is_last};
            if (!w_full) begin
               w_push = 1'b1;
               if (w_is_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            phy_ready_o = 1'b1;
            if (phy_valid_i && phy_last_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_beat_addr <= '0;
         r_phy_cnt   <= '0;
         r_beat_idx  <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_asm       <= '0;
         r_err       <= 1'b0;
         r_word_err  <= 1'b0;
         r_last_seen <= 1'b0;
      end else begin
         if (w_trans_hs) begin
            r_beat_addr <= CntWidth'(trans_addr_i);
            r_phy_cnt   <= CntWidth'(trans_addr_i) & ~CntWidth'(c_PHY_BYTES - 1);
            r_beat_idx  <= '0;
            r_len       <= trans_len_i;
            r_size      <= trans_size_i;
            r_asm       <= '0;
            r_err       <= 1'b0;
            r_word_err  <= 1'b0;
            r_last_seen <= 1'b0;
         end
         if (w_word_acc) begin
            for (int k = 0; k < c_WORDS; k++) begin
               if (r_phy_cnt[AddrWidth-1:0] == AddrWidth'(k * c_PHY_BYTES)) begin
                  r_asm[k*c_PHY_W +: c_PHY_W] <= phy_data_i;
               end
            end
            r_phy_cnt   <= r_phy_cnt + CntWidth'(c_PHY_BYTES);
            r_err       <= r_err | phy_error_i;
            r_word_err  <= phy_error_i;
            r_last_seen <= r_last_seen | phy_last_i;
         end
         if (w_push) begin
            r_beat_addr <= w_beat_end;
            r_beat_idx  <= r_beat_idx + 8'd1;
            // A narrow beat that still lies inside the last word inherits its error.
            r_err       <= (w_beat_end < r_phy_cnt) ? r_word_err : 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         for (int i = 0; i < OutDepth; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
            r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + c_FILL_W'(1);
            2'b01:   r_fill <= r_fill - c_FILL_W'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   assign axi_valid_o = (r_fill != '0);
   assign {axi_data_o, axi_error_o, axi_last_o} = r_mem[r_rd_ptr];

endmodule
`default_nettype wire
